// File: rtl/alarm_pkg.sv
// Shared types and width helpers for the sensor alarm controller.
package alarm_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ALARM = 1'b1
    } alarm_state_e;

    function automatic int ch_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    function automatic int cnt_w(input int deb_cyc, input int alarm_cyc);
        int m;
        m = (deb_cyc > alarm_cyc) ? deb_cyc : alarm_cyc;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/alarm_debounce.sv
// Per-channel debouncer: qualifies a sensor after DEB_CYC consecutive high samples.
module alarm_debounce
    import alarm_pkg::*;
#(
    parameter int DEB_CYC = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic sensor,
    output logic qual
);

    localparam int DW = cnt_w(DEB_CYC, DEB_CYC);

    logic [DW-1:0] cnt_q;

    // Pulse on the edge that takes the counter to DEB_CYC; saturation blocks re-qualification.
    assign qual = ena && sensor && (cnt_q == DW'(DEB_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (ena) begin
            if (!sensor) begin
                cnt_q <= '0;
            end else if (cnt_q != DW'(DEB_CYC)) begin
                cnt_q <= cnt_q + DW'(1);
            end
        end
    end

endmodule

// File: rtl/sensor_alarm_ctrl.sv
// N-channel sensor alarm controller: debounced events are queued and served one
// channel at a time, either for a timed window or until acknowledged.
module sensor_alarm_ctrl
    import alarm_pkg::*;
#(
    parameter  int N_CH      = 3,
    parameter  int DEB_CYC   = 7,
    parameter  int ALARM_CYC = 31,
    localparam int CH_W      = ch_w(N_CH),
    localparam int CNT_W     = cnt_w(DEB_CYC, ALARM_CYC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [N_CH-1:0] sensor_i,
    input  logic            latch_mode,
    input  logic            ack_i,
    output logic [N_CH-1:0] buzzer_o,
    output logic            alarm_active_o,
    output logic [CH_W-1:0] alarm_ch_o,
    output logic [N_CH-1:0] pending_o
);

    logic [N_CH-1:0]  qual;
    logic [N_CH-1:0]  pending_q, pending_d, pend_clr;
    logic [N_CH-1:0]  buzzer_q, buzzer_d;
    logic [N_CH-1:0]  grant_mask;
    logic [CH_W-1:0]  grant_idx;
    logic             grant_vld;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    alarm_state_e     state_q, state_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_deb
        alarm_debounce #(
            .DEB_CYC (DEB_CYC)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .ena    (ena),
            .sensor (sensor_i[g]),
            .qual   (qual[g])
        );
    end

    // Lowest set pending index wins.
    always_comb begin
        grant_idx  = '0;
        grant_mask = '0;
        grant_vld  = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant_idx     = CH_W'(i);
                grant_mask    = '0;
                grant_mask[i] = 1'b1;
                grant_vld     = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        buzzer_d = buzzer_q;
        ch_d     = ch_q;
        pend_clr = '0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d  = ALARM;
                    cnt_d    = CNT_W'(1);
                    buzzer_d = grant_mask;
                    ch_d     = grant_idx;
                    pend_clr = grant_mask;
                end
            end
            ALARM: begin
                // Counter keeps running in latch mode so a switch to timed exits promptly.
                if (ack_i || (!latch_mode && (cnt_q >= CNT_W'(ALARM_CYC)))) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    buzzer_d = '0;
                    ch_d     = '0;
                end else if (cnt_q < CNT_W'(ALARM_CYC)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                buzzer_d = '0;
                ch_d     = '0;
            end
        endcase
        active_d  = (state_d == ALARM);
        // A new qualification beats a same-cycle grant clear.
        pending_d = (pending_q & ~pend_clr) | qual;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            buzzer_q  <= '0;
            ch_q      <= '0;
            active_q  <= 1'b0;
            pending_q <= '0;
        end else if (ena) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buzzer_q  <= buzzer_d;
            ch_q      <= ch_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    assign buzzer_o       = buzzer_q;
    assign alarm_active_o = active_q;
    assign alarm_ch_o     = ch_q;
    assign pending_o      = pending_q;

endmodule

// File: tb/tb_sensor_alarm_ctrl.sv
// Directed self-checking bench for sensor_alarm_ctrl at default parameters.
module tb_sensor_alarm_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [2:0] sensor_i;
    logic       latch_mode;
    logic       ack_i;
    logic [2:0] buzzer_o;
    logic       alarm_active_o;
    logic [1:0] alarm_ch_o;
    logic [2:0] pending_o;

    int n_cmp = 0;
    int n_err = 0;

    sensor_alarm_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .sensor_i       (sensor_i),
        .latch_mode     (latch_mode),
        .ack_i          (ack_i),
        .buzzer_o       (buzzer_o),
        .alarm_active_o (alarm_active_o),
        .alarm_ch_o     (alarm_ch_o),
        .pending_o      (pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic qualify(input logic [2:0] pat);
        sensor_i = pat;
        repeat (7) tick();
        sensor_i = 3'b000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_cmp++; if (buzzer_o !== 3'b000) begin n_err++; $display("FAIL reset_buzzer got %b want 000", buzzer_o); end
        n_cmp++; if (alarm_active_o !== 1'b0) begin n_err++; $display("FAIL reset_active got %b want 0", alarm_active_o); end
        n_cmp++; if (alarm_ch_o !== 2'd0) begin n_err++; $display("FAIL reset_ch got %0d want 0", alarm_ch_o); end
        n_cmp++; if (pending_o !== 3'b000) begin n_err++; $display("FAIL reset_pending got %b want 000", pending_o); end
        rst_n = 1'b1;
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        tick();
        n_cmp++; if (alarm_active_o !== 1'b0 || buzzer_o !== 3'b000) begin
            n_err++; $display("FAIL idle_ack active=%b buzzer=%b want 0/000", alarm_active_o, buzzer_o);
        end
    endtask

    task automatic test_single();
        int on;
        sensor_i = 3'b001;
        repeat (6) tick();
        n_cmp++; if (pending_o !== 3'b000) begin n_err++; $display("FAIL single_pending6 got %b want 000", pending_o); end
        tick();
        sensor_i = 3'b000;
        n_cmp++; if (pending_o !== 3'b001) begin n_err++; $display("FAIL single_pending7 got %b want 001", pending_o); end
        n_cmp++; if (buzzer_o !== 3'b000) begin n_err++; $display("FAIL single_buzzer7 got %b want 000", buzzer_o); end
        tick();
        n_cmp++; if (buzzer_o !== 3'b001 || alarm_active_o !== 1'b1 || alarm_ch_o !== 2'd0 || pending_o !== 3'b000) begin
            n_err++; $display("FAIL single_grant buzzer=%b active=%b ch=%0d pend=%b want 001/1/0/000",
                              buzzer_o, alarm_active_o, alarm_ch_o, pending_o);
        end
        on = (buzzer_o == 3'b001) ? 1 : 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (buzzer_o == 3'b001) on++;
            else break;
        end
        n_cmp++; if (on !== 31) begin n_err++; $display("FAIL single_on_cycles got %0d want 31", on); end
        n_cmp++; if (buzzer_o !== 3'b000 || alarm_active_o !== 1'b0) begin
            n_err++; $display("FAIL single_end buzzer=%b active=%b want 000/0", buzzer_o, alarm_active_o);
        end
    endtask

    task automatic test_glitch();
        logic seen;
        seen = 1'b0;
        sensor_i = 3'b001;
        for (int i = 0; i < 6; i++) begin tick(); if (buzzer_o != 3'b000 || pending_o != 3'b000) seen = 1'b1; end
        sensor_i = 3'b000;
        tick();
        if (buzzer_o != 3'b000 || pending_o != 3'b000) seen = 1'b1;
        sensor_i = 3'b001;
        for (int i = 0; i < 6; i++) begin tick(); if (buzzer_o != 3'b000 || pending_o != 3'b000) seen = 1'b1; end
        sensor_i = 3'b000;
        for (int i = 0; i < 5; i++) begin tick(); if (buzzer_o != 3'b000 || pending_o != 3'b000) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL glitch_qualified got activity=%b want 0", seen); end
    endtask

    task automatic test_back_to_back();
        int on;
        qualify(3'b110);
        n_cmp++; if (pending_o !== 3'b110) begin n_err++; $display("FAIL b2b_pending got %b want 110", pending_o); end
        tick();
        n_cmp++; if (buzzer_o !== 3'b010 || alarm_ch_o !== 2'd1 || pending_o !== 3'b100) begin
            n_err++; $display("FAIL b2b_first buzzer=%b ch=%0d pend=%b want 010/1/100", buzzer_o, alarm_ch_o, pending_o);
        end
        repeat (30) tick();
        n_cmp++; if (buzzer_o !== 3'b010) begin n_err++; $display("FAIL b2b_first_last got %b want 010", buzzer_o); end
        tick();
        n_cmp++; if (buzzer_o !== 3'b000 || alarm_active_o !== 1'b0 || alarm_ch_o !== 2'd0) begin
            n_err++; $display("FAIL b2b_gap buzzer=%b active=%b ch=%0d want 000/0/0", buzzer_o, alarm_active_o, alarm_ch_o);
        end
        tick();
        n_cmp++; if (buzzer_o !== 3'b100 || alarm_ch_o !== 2'd2 || pending_o !== 3'b000) begin
            n_err++; $display("FAIL b2b_second buzzer=%b ch=%0d pend=%b want 100/2/000", buzzer_o, alarm_ch_o, pending_o);
        end
        on = (buzzer_o == 3'b100) ? 1 : 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (buzzer_o == 3'b100) on++;
            else break;
        end
        n_cmp++; if (on !== 31) begin n_err++; $display("FAIL b2b_second_on got %0d want 31", on); end
        tick();
    endtask

    task automatic test_latch();
        logic dropped;
        dropped = 1'b0;
        latch_mode = 1'b1;
        qualify(3'b100);
        tick();
        for (int i = 0; i < 105; i++) begin
            if (buzzer_o != 3'b100) dropped = 1'b1;
            tick();
        end
        n_cmp++; if (dropped !== 1'b0 || buzzer_o !== 3'b100) begin
            n_err++; $display("FAIL latch_hold dropped=%b buzzer=%b want 0/100", dropped, buzzer_o);
        end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        n_cmp++; if (buzzer_o !== 3'b000 || alarm_active_o !== 1'b0) begin
            n_err++; $display("FAIL latch_ack buzzer=%b active=%b want 000/0", buzzer_o, alarm_active_o);
        end
        tick();
        qualify(3'b001);
        tick();
        repeat (40) tick();
        n_cmp++; if (buzzer_o !== 3'b001) begin n_err++; $display("FAIL latch2_hold got %b want 001", buzzer_o); end
        latch_mode = 1'b0;
        tick();
        n_cmp++; if (buzzer_o !== 3'b000) begin n_err++; $display("FAIL latch_to_timed got %b want 000", buzzer_o); end
        tick();
    endtask

    task automatic test_ena_freeze();
        logic moved;
        int   rem;
        moved = 1'b0;
        qualify(3'b001);
        tick();
        repeat (9) tick();
        ena = 1'b0;
        sensor_i = 3'b010;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (buzzer_o != 3'b001 || alarm_active_o != 1'b1 || alarm_ch_o != 2'd0 || pending_o != 3'b000) moved = 1'b1;
        end
        n_cmp++; if (moved !== 1'b0) begin n_err++; $display("FAIL freeze_outputs changed=%b want 0", moved); end
        ena = 1'b1;
        sensor_i = 3'b000;
        rem = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (buzzer_o == 3'b001) rem++;
            else break;
        end
        n_cmp++; if (rem !== 21) begin n_err++; $display("FAIL freeze_remaining got %0d want 21", rem); end
        n_cmp++; if (pending_o !== 3'b000) begin n_err++; $display("FAIL freeze_ignored_sensor got %b want 000", pending_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic fired;
        fired = 1'b0;
        qualify(3'b101);
        tick();
        n_cmp++; if (buzzer_o !== 3'b001 || pending_o !== 3'b100) begin
            n_err++; $display("FAIL rmid_grant buzzer=%b pend=%b want 001/100", buzzer_o, pending_o);
        end
        repeat (14) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (buzzer_o !== 3'b000 || alarm_active_o !== 1'b0 || alarm_ch_o !== 2'd0 || pending_o !== 3'b000) begin
            n_err++; $display("FAIL rmid_async buzzer=%b active=%b ch=%0d pend=%b want all 0",
                              buzzer_o, alarm_active_o, alarm_ch_o, pending_o);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (buzzer_o != 3'b000 || pending_o != 3'b000 || alarm_active_o != 1'b0) fired = 1'b1;
        end
        n_cmp++; if (fired !== 1'b0) begin n_err++; $display("FAIL rmid_after_release activity=%b want 0", fired); end
    endtask

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b1;
        sensor_i   = 3'b000;
        latch_mode = 1'b0;
        ack_i      = 1'b0;
        test_reset();
        test_single();
        test_glitch();
        test_back_to_back();
        test_latch();
        test_ena_freeze();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
